// File: rtl/data_path.sv
// K&S processor execution datapath: PC, IR, register bank, ALU and flags.
// Decodes IR for the control FSM and sources RAM address and write data.
package data_path_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV,
        I_LOAD, I_STORE, I_MOVE,
        I_ADD, I_SUB, I_AND, I_OR,
        I_HALT
    } decoded_instruction_type;
endpackage

module data_path
    import data_path_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ir_enable,
    input  logic                    pc_enable,
    input  logic                    branch,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic                    write_reg_enable,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    input  logic [DATA_W-1:0]       data_in,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic              zero_q, neg_q, uov_q, sov_q;

    logic [1:0]        wr_idx, a_idx, b_idx;
    logic [DATA_W-1:0] op_a, op_b, alu_res, wr_data;
    logic [DATA_W:0]   ext;
    logic              alu_zero, alu_neg, alu_uov, alu_sov;
    logic [7:0]        opcode;

    assign opcode = ir_q[15:8];

    always_comb begin
        decoded_instruction = I_NOP;
        case (opcode)
            8'h01:   decoded_instruction = I_BRANCH;
            8'h02:   decoded_instruction = I_BZERO;
            8'h03:   decoded_instruction = I_BNEG;
            8'h04:   decoded_instruction = I_BOV;
            8'h05:   decoded_instruction = I_BNOV;
            8'h81:   decoded_instruction = I_LOAD;
            8'h82:   decoded_instruction = I_STORE;
            8'h91:   decoded_instruction = I_MOVE;
            8'hA1:   decoded_instruction = I_ADD;
            8'hA2:   decoded_instruction = I_SUB;
            8'hA3:   decoded_instruction = I_AND;
            8'hA4:   decoded_instruction = I_OR;
            8'hFF:   decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    // MOVE reuses the ALU as OR with both operands the source register.
    always_comb begin
        wr_idx = ir_q[5:4];
        a_idx  = ir_q[3:2];
        b_idx  = ir_q[1:0];
        case (decoded_instruction)
            I_LOAD: begin
                wr_idx = ir_q[6:5];
                a_idx  = ir_q[6:5];
            end
            I_STORE: a_idx = ir_q[6:5];
            I_MOVE: begin
                wr_idx = ir_q[3:2];
                a_idx  = ir_q[1:0];
                b_idx  = ir_q[1:0];
            end
            default: ;
        endcase
    end

    assign op_a = regs_q[a_idx];
    assign op_b = regs_q[b_idx];

    always_comb begin
        ext     = '0;
        alu_res = '0;
        alu_uov = 1'b0;
        alu_sov = 1'b0;
        case (operation)
            2'b00: alu_res = op_a | op_b;
            2'b01: begin
                ext     = {1'b0, op_a} + {1'b0, op_b};
                alu_res = ext[DATA_W-1:0];
                alu_uov = ext[DATA_W];
                alu_sov = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            2'b10: begin
                ext     = {1'b0, op_a} - {1'b0, op_b};
                alu_res = ext[DATA_W-1:0];
                alu_uov = ext[DATA_W];
                alu_sov = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            default: alu_res = op_a & op_b;
        endcase
    end

    assign alu_zero = (alu_res == '0);
    assign alu_neg  = alu_res[DATA_W-1];

    assign wr_data = c_sel ? data_in : alu_res;

    always_comb begin
        pc_d = pc_q;
        if (pc_enable) begin
            if (branch) pc_d = ir_q[ADDR_W-1:0];
            else        pc_d = pc_q + ADDR_W'(1);
        end
        ir_d = ir_enable ? data_in : ir_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (write_reg_enable) begin
            regs_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            uov_q  <= 1'b0;
            sov_q  <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_q <= alu_zero;
            neg_q  <= alu_neg;
            uov_q  <= alu_uov;
            sov_q  <= alu_sov;
        end
    end

    assign ram_addr          = addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
    assign data_out          = op_a;
    assign zero_op           = zero_q;
    assign neg_op            = neg_q;
    assign unsigned_overflow = uov_q;
    assign signed_overflow   = sov_q;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: hand-computed vectors checked with
// immediate assertions.
module tb_data_path;
    import data_path_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ir_enable, pc_enable, branch, addr_sel, c_sel;
    logic        write_reg_enable, flags_reg_enable;
    logic [1:0]  operation;
    logic [15:0] data_in;
    logic [4:0]  ram_addr;
    logic [15:0] data_out;
    decoded_instruction_type decoded_instruction;
    logic        zero_op, neg_op, unsigned_overflow, signed_overflow;

    int checks = 0;
    int errors = 0;

    data_path dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ir_enable           (ir_enable),
        .pc_enable           (pc_enable),
        .branch              (branch),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .write_reg_enable    (write_reg_enable),
        .operation           (operation),
        .flags_reg_enable    (flags_reg_enable),
        .data_in             (data_in),
        .ram_addr            (ram_addr),
        .data_out            (data_out),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, zero_op, neg_op, unsigned_overflow,
                  signed_overflow}, {28'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ir_enable        = 1'b0;
        pc_enable        = 1'b0;
        branch           = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        operation        = 2'b00;
    endtask

    task automatic load_ir(input logic [15:0] v);
        data_in   = v;
        ir_enable = 1'b1;
        tick();
        ir_enable = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] r, input logic [15:0] v);
        load_ir(16'h8105 | (16'(r) << 5));
        data_in          = v;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        tick();
        idle();
    endtask

    task automatic read_reg(input logic [1:0] r, output logic [15:0] v);
        load_ir(16'h8200 | (16'(r) << 5));
        v = data_out;
    endtask

    logic [15:0] rv;

    initial begin
        idle();
        data_in = 16'h0000;
        rst_n   = 1'b0;
        #12;
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_dec", 32'(decoded_instruction), 32'(I_NOP));
        chk_flags("rst_flags", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick();
        chk("hold_addr", 32'(ram_addr), 32'd0);
        chk("hold_dec", 32'(decoded_instruction), 32'(I_NOP));
        chk_flags("hold_flags", 4'b0000);

        // LOAD r1 from address 5, then STORE it back
        load_ir(16'h8125);
        chk("dec_load", 32'(decoded_instruction), 32'(I_LOAD));
        addr_sel = 1'b1;
        #1;
        chk("load_addr", 32'(ram_addr), 32'd5);
        data_in          = 16'h1234;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        tick();
        idle();
        load_ir(16'h8225);
        chk("dec_store", 32'(decoded_instruction), 32'(I_STORE));
        chk("store_data", 32'(data_out), 32'h1234);

        // ADD r0 = r1 + r2 with signed overflow
        write_reg(2'd1, 16'h7FFF);
        write_reg(2'd2, 16'h0001);
        load_ir(16'hA1C6);
        chk("dec_add", 32'(decoded_instruction), 32'(I_ADD));
        chk("add_opa", 32'(data_out), 32'h7FFF);
        operation        = 2'b01;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        tick();
        idle();
        chk_flags("add_flags", 4'b0101);
        read_reg(2'd0, rv);
        chk("add_res", 32'(rv), 32'h8000);

        // SUB equal operands, then borrow
        write_reg(2'd1, 16'h0005);
        write_reg(2'd2, 16'h0005);
        load_ir(16'hA206);
        chk("dec_sub", 32'(decoded_instruction), 32'(I_SUB));
        operation        = 2'b10;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        tick();
        idle();
        chk_flags("sub_eq_flags", 4'b1000);
        read_reg(2'd0, rv);
        chk("sub_eq_res", 32'(rv), 32'h0000);
        write_reg(2'd1, 16'h0000);
        load_ir(16'hA206);
        operation        = 2'b10;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        tick();
        idle();
        chk_flags("sub_bw_flags", 4'b0110);
        read_reg(2'd0, rv);
        chk("sub_bw_res", 32'(rv), 32'hFFFB);
        chk_flags("flags_hold", 4'b0110);

        // MOVE r1 <- r2 through the ALU OR path
        load_ir(16'h9106);
        chk("dec_move", 32'(decoded_instruction), 32'(I_MOVE));
        chk("move_src", 32'(data_out), 32'h0005);
        operation        = 2'b00;
        write_reg_enable = 1'b1;
        tick();
        idle();
        read_reg(2'd1, rv);
        chk("move_res", 32'(rv), 32'h0005);

        // PC branch, wrap, increment
        load_ir(16'h011F);
        chk("dec_branch", 32'(decoded_instruction), 32'(I_BRANCH));
        pc_enable = 1'b1;
        branch    = 1'b1;
        tick();
        idle();
        chk("pc_31", 32'(ram_addr), 32'd31);
        pc_enable = 1'b1;
        tick();
        idle();
        chk("pc_wrap", 32'(ram_addr), 32'd0);
        load_ir(16'h0111);
        pc_enable = 1'b1;
        branch    = 1'b1;
        tick();
        idle();
        chk("pc_17", 32'(ram_addr), 32'd17);
        branch = 1'b1;
        tick();
        idle();
        chk("pc_nobr", 32'(ram_addr), 32'd17);
        pc_enable = 1'b1;
        tick();
        idle();
        chk("pc_inc", 32'(ram_addr), 32'd18);

        // fetch: IR load and PC increment in the same edge
        data_in   = 16'h0203;
        ir_enable = 1'b1;
        pc_enable = 1'b1;
        #1;
        chk("fetch_pre", 32'(ram_addr), 32'd18);
        tick();
        idle();
        chk("fetch_post", 32'(ram_addr), 32'd19);
        chk("dec_bzero", 32'(decoded_instruction), 32'(I_BZERO));

        load_ir(16'h7E00);
        chk("dec_bad", 32'(decoded_instruction), 32'(I_NOP));
        load_ir(16'hFF00);
        chk("dec_halt", 32'(decoded_instruction), 32'(I_HALT));

        // reset asserted in the middle of a register write
        load_ir(16'h8105);
        data_in          = 16'hABCD;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_addr", 32'(ram_addr), 32'd0);
        chk("mrst_dec", 32'(decoded_instruction), 32'(I_NOP));
        chk_flags("mrst_flags", 4'b0000);
        tick();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int r = 0; r < 4; r++) begin
            read_reg(2'(r), rv);
            chk($sformatf("mrst_r%0d", r), 32'(rv), 32'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- Execution datapath of the K&S processor. It holds the PC, IR, the 4x16 register bank, the ALU and the flags register.
- It decodes IR into decoded_instruction for the control FSM and sources the RAM address and write data.
- Every state change is gated by the strobes the control FSM issues.

Parameters:
- DATA_W, 16, width of registers, ALU and RAM data.
- ADDR_W, 5, width of PC and RAM address (32-word memory).
- NREGS, 4, register bank depth (2-bit register fields).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ir_enable  in  1  load IR from data_in.
- pc_enable  in  1  update PC.
- branch  in  1  with pc_enable: PC <= IR[4:0], otherwise PC+1.
- addr_sel  in  1  ram_addr source: 1 = IR[4:0], 0 = PC.
- c_sel  in  1  register write source: 1 = data_in, 0 = ALU result.
- write_reg_enable  in  1  write register bank.
- operation  in  2  ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND.
- flags_reg_enable  in  1  latch ALU flags.
- data_in  in  DATA_W  RAM read data.
- ram_addr  out  ADDR_W  RAM address.
- data_out  out  DATA_W  RAM write data.
- decoded_instruction  out  decoded_instruction_type  decode of current IR.
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags.

Behaviour:
- Reset (async, immediate): PC=0, IR=0, all registers=0, all flags=0. ram_addr=0. decoded_instruction=I_NOP.
- IR format:
  - IR[15:8] opcode.
  - ALU ops: dest IR[5:4], srcA IR[3:2], srcB IR[1:0].
  - LOAD/STORE: reg IR[6:5], addr IR[4:0].
  - MOVE: dest IR[3:2], src IR[1:0].
  - Branches: target IR[4:0].
- Decode (combinational from IR):
  - 0x00 I_NOP, 0x01 I_BRANCH, 0x02 I_BZERO, 0x03 I_BNEG, 0x04 I_BOV, 0x05 I_BNOV.
  - 0x81 I_LOAD, 0x82 I_STORE, 0x91 I_MOVE.
  - 0xA1 I_ADD, 0xA2 I_SUB, 0xA3 I_AND, 0xA4 I_OR.
  - 0xFF I_HALT. Any other opcode -> I_NOP.
- Register-field select by decoded type:
  - Write index: LOAD -> IR[6:5]; MOVE -> IR[3:2]; else IR[5:4].
  - Operand A: LOAD/STORE -> IR[6:5]; MOVE -> IR[1:0]; else IR[3:2].
  - Operand B: IR[1:0]. For MOVE it is forced equal to A, so OR passes A through.
- ALU (combinational, DATA_W bits, result wraps mod 2^16):
  - ADD: unsigned_overflow = carry out; signed_overflow = operands same sign and result sign differs.
  - SUB (A-B): unsigned_overflow = borrow (A<B unsigned); signed_overflow = operand signs differ and result sign differs from A.
  - OR/AND: both overflows 0.
  - zero = (result==0); neg = result[15].
- Flags: on flags_reg_enable, all four latch together at the edge; otherwise they hold. Outputs are the registered values only.
- Register bank:
  - Reads are combinational from current contents.
  - On write_reg_enable, the edge writes c_sel ? data_in : ALU result.
  - A read of the register being written in that cycle returns the old value.
  - A flag update in the same cycle uses the pre-edge operands.
- data_out = operand A register (the STORE source).
- ram_addr = addr_sel ? IR[4:0] : PC.
- IR: on ir_enable, IR <= data_in; otherwise it holds.
- PC:
  - pc_enable & branch -> PC <= IR[4:0].
  - pc_enable & !branch -> PC <= PC+1; 31 wraps to 0.
  - branch without pc_enable is ignored.
- Simultaneous ir_enable and pc_enable: IR captures data_in at the current PC. ram_addr changes only after the edge.
- Mid-operation reset: all state clears immediately. Partial register writes are discarded.

Test Plan:
- Reset then release with all strobes 0 -> PC=0, ram_addr=0, decoded_instruction=I_NOP, flags 0. State holds for 10 cycles.
- data_in=0x8125, ir_enable=1 -> I_LOAD. Then addr_sel=1 -> ram_addr=5. data_in=0x1234, c_sel=1, write_reg_enable=1 -> r1=0x1234. Then STORE 0x8225 -> data_out=0x1234.
- r1=0x7FFF, r2=0x0001, IR=0xA1C6 (ADD r0=r1+r2), operation=01, write+flags enable -> r0=0x8000, neg=1, signed_overflow=1, unsigned_overflow=0, zero=0.
- r1=r2=0x0005, SUB IR=0xA206, operation=10, flags enable -> r0=0, zero=1, all others 0. Then r1=0 -> unsigned_overflow=1, result 0xFFFB.
- PC=31, pc_enable=1, branch=0 -> PC=0. Then IR=0x0111, pc_enable=1, branch=1 -> PC=17. branch=1 with pc_enable=0 -> PC unchanged.
- Opcode 0x7E -> I_NOP. Assert rst_n low mid-write with write_reg_enable=1 -> all registers read 0 after reset.
